// File: rtl/idct_8x8_engine.sv
// Sequential 8x8 inverse DCT: buffers 64 coefficients, then rebuilds each pixel by a 64-term MAC.
// Optional macro IDCT_LEVEL_SHIFT_EN selects unsigned level-shifted pixels instead of signed ones.
module idct_8x8_engine #(
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_pixel,
    output logic                     out_last,
    output logic                     busy
);

    localparam int ACC_W  = DATA_W + 24;
    localparam int PROD_W = DATA_W + 18;
    localparam int R_W    = ACC_W - 18;

`ifdef IDCT_LEVEL_SHIFT_EN
    localparam logic signed [R_W-1:0] PIX_OFF = R_W'(128);
    localparam logic signed [R_W-1:0] PIX_MIN = R_W'(0);
    localparam logic signed [R_W-1:0] PIX_MAX = R_W'(255);
`else
    localparam logic signed [R_W-1:0] PIX_OFF = R_W'(0);
    localparam logic signed [R_W-1:0] PIX_MIN = R_W'(-128);
    localparam logic signed [R_W-1:0] PIX_MAX = R_W'(127);
`endif

    typedef enum logic [1:0] {LOAD, MAC, ROUND, EMIT} state_t;

    state_t                     state, next_state;
    logic [5:0]                 cnt;
    logic [5:0]                 pix;
    logic [6:0]                 term;
    logic signed [DATA_W-1:0]   buffer [64];
    logic signed [8:0]          cos_row, cos_col;
    logic signed [17:0]         basis;
    logic signed [PROD_W-1:0]   prod;
    logic                       prod_valid;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    biased;
    logic signed [R_W-1:0]      r, lvl;
    logic [7:0]                 sat;
    logic                       in_fire, out_fire;

    // Q8 cosine basis; the angle (2n+1)k is folded onto the first quadrant.
    function automatic logic signed [8:0] cos_q8(input logic [2:0] k, input logic [2:0] n);
        logic [6:0] angle;
        logic [4:0] m;
        logic [4:0] fold;
        logic       neg;
        logic [7:0] mag;
        angle = 7'({n, 1'b1}) * 7'(k);
        m     = angle[4:0];
        fold  = m;
        neg   = 1'b0;
        if (m > 5'd8 && m <= 5'd16) begin
            fold = 5'd16 - m;
            neg  = 1'b1;
        end else if (m > 5'd16 && m <= 5'd24) begin
            fold = m - 5'd16;
            neg  = 1'b1;
        end else if (m > 5'd24) begin
            fold = 5'd0 - m;
        end
        case (fold)
            5'd1:    mag = 8'd251;
            5'd2:    mag = 8'd237;
            5'd3:    mag = 8'd213;
            5'd4:    mag = 8'd181;
            5'd5:    mag = 8'd142;
            5'd6:    mag = 8'd98;
            5'd7:    mag = 8'd50;
            default: mag = 8'd0;
        endcase
        if (k == 3'd0) return 9'sd181;
        return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == EMIT);
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != LOAD);

    assign cos_row = cos_q8(term[5:3], pix[5:3]);
    assign cos_col = cos_q8(term[2:0], pix[2:0]);
    assign basis   = 18'(cos_row) * 18'(cos_col);

    always_comb begin
        next_state = state;
        case (state)
            LOAD:  if (in_fire && cnt == 6'd63) next_state = MAC;
            MAC:   if (term == 7'd65) next_state = ROUND;
            ROUND: next_state = EMIT;
            EMIT:  if (out_fire) next_state = (pix == 6'd63) ? LOAD : MAC;
            default: next_state = LOAD;
        endcase
    end

    // Rounding removes Q16 plus the 1/4 normalisation, then the pixel format is saturated.
    always_comb begin
        biased = acc + ACC_W'(131072);
        r      = biased[ACC_W-1:18];
        lvl    = r + PIX_OFF;
        sat    = lvl[7:0];
        if (lvl < PIX_MIN) sat = PIX_MIN[7:0];
        else if (lvl > PIX_MAX) sat = PIX_MAX[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= 6'd0;
            pix       <= 6'd0;
            term      <= 7'd0;
            in_ready  <= 1'b0;
            out_pixel <= 8'd0;
            out_last  <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == LOAD);
            case (state)
                LOAD: begin
                    if (in_fire) cnt <= cnt + 6'd1;
                    term <= 7'd0;
                end
                MAC: term <= term + 7'd1;
                ROUND: begin
                    out_pixel <= sat;
                    out_last  <= (pix == 6'd63);
                end
                EMIT: begin
                    if (out_fire) begin
                        pix      <= pix + 6'd1;
                        term     <= 7'd0;
                        out_last <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) buffer[cnt] <= in_coef;
    end

    // Product stage followed by accumulate stage; terms 64 and 65 only drain the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod       <= PROD_W'(buffer[term[5:0]]) * PROD_W'(basis);
            prod_valid <= (state == MAC) && !term[6];
            if (state == MAC && term == 7'd0) acc <= '0;
            else if (prod_valid) acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Randomised self-checking bench for idct_8x8_engine against a real-valued cosine reference.
module tb_idct_8x8_engine;

    localparam int DATA_W = 12;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_coef = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [7:0]               out_pixel;
    logic                     out_last;
    logic                     busy;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int blk [64];
    int exp_pix [64];

    idct_8x8_engine #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every comparison funnels through here so counts stay consistent.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        else
            passes++;
    endtask

    function automatic int tcos(input int k, input int n);
        real c, x;
        c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        x = 256.0 * c * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
        return (x >= 0.0) ? $rtoi($floor(x + 0.5)) : -$rtoi($floor(-x + 0.5));
    endfunction

    task automatic computeExpected();
        for (int p = 0; p < 64; p++) begin
            longint acc = 0;
            longint r;
            for (int k1 = 0; k1 < 8; k1++)
                for (int k2 = 0; k2 < 8; k2++)
                    acc += longint'(blk[k1*8+k2]) * tcos(k1, p / 8) * tcos(k2, p % 8);
            r = (acc + 131072) >>> 18;
`ifdef IDCT_LEVEL_SHIFT_EN
            r = r + 128;
            if (r < 0) r = 0;
            if (r > 255) r = 255;
`else
            if (r < -128) r = -128;
            if (r > 127) r = 127;
`endif
            exp_pix[p] = int'(r) & 255;
        end
    endtask

    task automatic fillDc(input int dc);
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = dc;
    endtask

    task automatic fillRandom(input int span);
        for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 2 * span)) - span;
    endtask

    // Drive one block with random idle gaps; all driving happens on falling edges.
    task automatic applyStimulus(input bit gaps);
        int waited;
        computeExpected();
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_coef  = DATA_W'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_coef  = DATA_W'(blk[i]);
            waited   = 0;
            while (!in_ready && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid    = 1'b0;
        last_in_cyc = cyc;
        checkOutput("in_ready_drop", int'(in_ready), 0);
    endtask

    // Collect pixels; optional stall on one pixel, optional reset after another.
    task automatic collectBlock(input int stall_at, input int abort_at, input bit toggle_in);
        int prev, waited;
        logic [7:0] held;
        prev = last_in_cyc;
        for (int p = 0; p < 64; p++) begin
            waited = 0;
            while (!out_valid && waited < 300) begin
                if (toggle_in) begin
                    in_valid = 1'($urandom);
                    in_coef  = DATA_W'($urandom);
                end
                @(negedge clk);
                waited++;
            end
            if (!out_valid) begin
                checkOutput("out_valid_timeout", 0, 1);
                return;
            end
            checkOutput("latency", cyc - prev, 67);
            checkOutput("pixel", int'(out_pixel), exp_pix[p]);
            checkOutput("last", int'(out_last), (p == 63) ? 1 : 0);
            if (p == stall_at) begin
                out_ready = 1'b0;
                held = out_pixel;
                repeat (10) begin
                    in_valid = 1'($urandom);
                    in_coef  = DATA_W'($urandom);
                    @(negedge clk);
                    checkOutput("stall_pixel", int'(out_pixel), int'(held));
                    checkOutput("stall_valid", int'(out_valid), 1);
                    checkOutput("stall_in_ready", int'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            prev = cyc;
            checkOutput("valid_after_hs", int'(out_valid), 0);
            if (p == 63) checkOutput("in_ready_back", int'(in_ready), 1);
            if (p == abort_at) begin
                in_valid = 1'b0;
                reset = 1'b1;
                #1;
                checkOutput("rst_in_ready", int'(in_ready), 0);
                checkOutput("rst_out_valid", int'(out_valid), 0);
                checkOutput("rst_out_last", int'(out_last), 0);
                checkOutput("rst_out_pixel", int'(out_pixel), 0);
                checkOutput("rst_busy", int'(busy), 0);
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk);
                #1;
                checkOutput("rst_release_ready", int'(in_ready), 1);
                @(negedge clk);
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_out_pixel", int'(out_pixel), 0);
        checkOutput("reset_out_last", int'(out_last), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", int'(in_ready), 1);
        @(negedge clk);

        fillDc(0);      applyStimulus(1'b1); collectBlock(-1, -1, 1'b0);
        fillDc(64);     applyStimulus(1'b0); collectBlock(-1, -1, 1'b0);
        fillDc(0); blk[1] = 100;
        applyStimulus(1'b1); collectBlock(-1, -1, 1'b0);
        fillDc(2047);   applyStimulus(1'b0); collectBlock(-1, -1, 1'b0);
        fillDc(-2048);  applyStimulus(1'b1); collectBlock(-1, -1, 1'b0);
        fillRandom(200); applyStimulus(1'b1); collectBlock(5, -1, 1'b1);
        fillRandom(2047); applyStimulus(1'b1); collectBlock(-1, 20, 1'b0);
        fillDc(64);     applyStimulus(1'b1); collectBlock(-1, -1, 1'b0);
        fillRandom(400); applyStimulus(1'b1); collectBlock(40, -1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
